// File: rtl/blur_frame_capture.sv
// blur_frame_capture: skips filter warm-up beats, then writes one frame.
// Define BLUR_CAPTURE_BORDER_ZERO_EN to force the 2-pixel border to zero.
module blur_frame_capture #(
    parameter int IMG_W   = 400,
    parameter int IMG_H   = 300,
    parameter int LATENCY = 802,
    parameter int ADDR_W  = 17
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clk_en,
    input  logic [7:0]        din,
    input  logic              start,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, DRAIN} state_t;

    localparam int NPIX = IMG_W * IMG_H;
    localparam int SKIP_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST =
        SKIP_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NPIX - 1);

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        fifo_data [4];
    logic [ADDR_W-1:0] fifo_addr [4];
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic [2:0]        count;
    logic              arm;
    logic              advance;
    logic              push;
    logic              pop;
    logic [7:0]        pix;

    assign arm     = (state == IDLE) && start;
    assign advance = (state == CAPTURE) && Clk_en;
    assign pop     = wr_en && wr_ready;
    // A full FIFO still takes a beat when the head leaves this cycle.
    assign push    = advance && ((count != 3'd4) || pop);
    assign wr_en   = (count != 3'd0);
    assign wr_addr = fifo_addr[rd_ptr];
    assign wr_data = fifo_data[rd_ptr];
    assign busy    = (state != IDLE);

`ifdef BLUR_CAPTURE_BORDER_ZERO_EN
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             border;

    always_ff @(posedge Clk) begin
        if (!Reset_n || arm) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign border = (row < ROW_W'(2)) || (row >= ROW_W'(IMG_H - 2)) ||
                    (col < COL_W'(2)) || (col >= COL_W'(IMG_W - 2));
    assign pix = border ? 8'd0 : din;
`else
    assign pix = din;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            skip_cnt   <= '0;
            addr       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push) begin
                fifo_data[wr_ptr] <= pix;
                fifo_addr[wr_ptr] <= addr;
                wr_ptr <= wr_ptr + 1'b1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};

            unique case (state)
                IDLE: begin
                    if (start) begin
                        overflow <= 1'b0;
                        skip_cnt <= '0;
                        addr     <= '0;
                        state    <= (LATENCY == 0) ? CAPTURE : SKIP;
                    end
                end
                SKIP: begin
                    if (Clk_en) begin
                        if (skip_cnt == SKIP_LAST)
                            state <= CAPTURE;
                        else
                            skip_cnt <= skip_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (Clk_en) begin
                        // Dropped beats still consume an address.
                        if (!push)
                            overflow <= 1'b1;
                        addr <= addr + 1'b1;
                        if (addr == ADDR_LAST)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((count == 3'd0) || (pop && count == 3'd1)) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blur_frame_capture.sv
// tb_blur_frame_capture: randomized bench with a queue-based frame model.
// Honours BLUR_CAPTURE_BORDER_ZERO_EN when the build defines it.
module tb_blur_frame_capture;
    localparam int W   = 8;
    localparam int H   = 6;
    localparam int LAT = 18;
    localparam int AW  = 6;
    localparam int N   = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ce = 1'b0;
    logic          start = 1'b0;
    logic          rdy = 1'b0;
    logic [7:0]    din = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;
    logic          overflow;

    blur_frame_capture #(
        .IMG_W(W), .IMG_H(H), .LATENCY(LAT), .ADDR_W(AW)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .Clk_en(ce), .din(din),
        .start(start), .wr_ready(rdy), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;
    ent_t mq[$];
    bit   m_act = 0;
    bit   m_done = 0;
    bit   m_ovf = 0;
    int   m_beats = 0;
    int   ce_mode = 0;
    int   rdy_mode = 0;
    int   din_mode = 0;
    int   ph = 0;
    int   rdy_low = 0;
    int   n_wr, n_done, gaps, n_ff;
    logic [AW-1:0] first_a, last_a;
    logic [7:0]    first_d, last_d;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

`ifdef BLUR_CAPTURE_BORDER_ZERO_EN
    function automatic bit border_zero(input int a);
        int r, c;
        r = a / W;
        c = a % W;
        return (r < 2) || (r >= H - 2) || (c < 2) || (c >= W - 2);
    endfunction
`endif

    // Frame model: beats since start, pixel k = beat LAT+k at address k.
    task automatic model_step();
        bit   pop;
        int   b;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_act = 0; m_done = 0; m_ovf = 0; m_beats = 0;
            return;
        end
        m_done = 0;
        b = m_beats;
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (m_act && ce && b >= LAT && b < LAT + N) begin
            e.a = AW'(b - LAT);
            e.d = din;
`ifdef BLUR_CAPTURE_BORDER_ZERO_EN
            if (border_zero(b - LAT)) e.d = 8'd0;
`endif
            if (mq.size() == 4) m_ovf = 1;
            else mq.push_back(e);
        end
        if (m_act && ce && b < LAT + N) m_beats++;
        if (m_act && b == LAT + N && pop && mq.size() == 0) begin
            m_act = 0;
            m_done = 1;
        end else if (!m_act && start) begin
            m_act = 1;
            m_beats = 0;
            m_ovf = 0;
        end
    endtask

    task automatic cycle(input bit st, input bit rn);
        @(negedge clk);
        if (chk_en) begin
            chk("wr_en", wr_en, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("wr_addr", wr_addr, mq[0].a);
                chk("wr_data", wr_data, mq[0].d);
            end
            chk("busy", busy, m_act);
            chk("frame_done", frame_done, m_done);
            chk("overflow", overflow, m_ovf);
        end
        if (frame_done === 1'b1) n_done++;
        rst_n = rn;
        start = st;
        unique case (ce_mode)
            0: ce = 1'b1;
            1: ce = (ph % 2 == 0);
            default: ce = 1'($urandom_range(0, 1));
        endcase
        ph++;
        if (rdy_low > 0) begin
            rdy = 1'b0;
            rdy_low--;
        end else begin
            rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        unique case (din_mode)
            0: din = 8'(m_beats);
            1: din = 8'hFF;
            default: din = 8'($urandom);
        endcase
        if (wr_en === 1'b1 && rdy && rn) begin
            if (n_wr == 0) begin
                first_a = wr_addr;
                first_d = wr_data;
            end else if (wr_addr != last_a + 1'b1) begin
                gaps += int'(wr_addr) - int'(last_a) - 1;
            end
            last_a = wr_addr;
            last_d = wr_data;
            if (wr_data == 8'hFF) n_ff++;
            n_wr++;
        end
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1);
    endtask

    // One frame; hooks fire once at the given beat index (-1 = never).
    task automatic run_frame(input int low_at, input int rst_at,
                             input int st2_at, input bit rnd_st);
        bit low_done, st2_done, st;
        n_wr = 0; n_done = 0; gaps = 0; n_ff = 0;
        low_done = 0; st2_done = 0;
        ph = 0;
        cycle(1, 1);
        for (int i = 0; i < 3000; i++) begin
            st = rnd_st && ($urandom_range(0, 15) == 0);
            if (m_act && !low_done && m_beats == low_at) begin
                rdy_low = 6;
                low_done = 1;
            end
            if (m_act && !st2_done && m_beats == st2_at) begin
                st = 1;
                st2_done = 1;
            end
            if (m_act && m_beats == rst_at) begin
                cycle(0, 0);
                cycle(0, 1);
                return;
            end
            cycle(st, 1);
            if (n_done > 0) break;
        end
        idle(3);
        chk("frame_done_once", n_done, 1);
    endtask

    initial begin
        cycle(0, 0);
        cycle(0, 0);
        chk_en = 1;
        cycle(0, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);

        for (int t = 0; t < 2; t++) begin
            ce_mode = t;
            run_frame(-1, -1, -1, 0);
            chk("base_writes", n_wr, 48);
            chk("base_first_addr", first_a, 0);
            chk("base_last_addr", last_a, 47);
            chk("base_gaps", gaps, 0);
            chk("base_overflow", overflow, 0);
`ifndef BLUR_CAPTURE_BORDER_ZERO_EN
            chk("base_first_data", first_d, 18);
            chk("base_last_data", last_d, 65);
`endif
            idle(2);
        end

        ce_mode = 0;
        run_frame(LAT + 10, -1, -1, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_dropped", gaps, 3);
        chk("ovf_total", n_wr + gaps, 48);
        chk("ovf_last_addr", last_a, 47);
        idle(2);

        run_frame(-1, LAT + 30, -1, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_busy", busy, 0);
        n_done = 0;
        idle(6);
        chk("abort_no_done", n_done, 0);
        run_frame(-1, -1, -1, 0);
        chk("after_abort_writes", n_wr, 48);

        run_frame(-1, -1, 5, 0);
        chk("restart_ignored_writes", n_wr, 48);
        idle(2);

        din_mode = 1;
        run_frame(-1, -1, -1, 0);
`ifdef BLUR_CAPTURE_BORDER_ZERO_EN
        chk("border_ff_count", n_ff, 8);
`else
        chk("border_ff_count", n_ff, 48);
`endif
        idle(2);

        ce_mode = 2; rdy_mode = 1; din_mode = 2;
        for (int f = 0; f < 4; f++) begin
            run_frame(-1, -1, -1, 1);
            idle($urandom_range(0, 4));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
